// File: rtl/instr_mem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction store, little-endian, one byte per cycle.
// Five-state FSM; every output is decoded from registered state so nothing combinational leaks from the inputs.
module instr_mem_loader #(
  parameter int MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  input  logic        in_last,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  // Highest byte address at which a whole word still fits in the store.
  localparam logic [63:0] LAST_WORD_ADDR = 64'(MEM_BYTES - 4);

  logic [2:0]  state;
  logic [63:0] addr;
  logic [31:0] word;
  logic        last;
  logic [1:0]  byte_idx;
  logic [63:0] next_addr;
  logic        base_bad;

  assign next_addr = addr + 64'd4;
  assign base_bad  = (base_addr[1:0] != 2'b00) || (base_addr > LAST_WORD_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      addr       <= '0;
      word       <= '0;
      last       <= 1'b0;
      byte_idx   <= '0;
      word_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (base_bad) begin
              state <= S_ERROR;
            end else begin
              addr       <= base_addr;
              word_count <= '0;
              state      <= S_ACCEPT;
            end
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            word     <= in_word;
            last     <= in_last;
            byte_idx <= '0;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            word_count <= word_count + 16'd1;
            addr       <= next_addr;
            // A final word may end exactly at the top of the store; only a continuation must fit.
            if (last) begin
              state <= S_DONE;
            end else if (next_addr > LAST_WORD_ADDR) begin
              state <= S_ERROR;
            end else begin
              state <= S_ACCEPT;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERROR: state <= S_ERROR;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_ACCEPT);
  assign mem_we    = (state == S_WRITE);
  assign mem_addr  = mem_we ? (addr + {62'd0, byte_idx}) : '0;
  assign mem_wdata = mem_we ? word[{byte_idx, 3'b000} +: 8] : '0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERROR);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: session table, randomized sessions against a byte-level reference model,
// and hand sequences for sticky error and mid-write reset.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [63:0] base_addr;
  logic [31:0] in_word;

  logic        in_ready, mem_we, busy, done, error;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [15:0] word_count;

  logic        s_in_ready, s_mem_we, s_busy, s_done, s_error;
  logic [63:0] s_mem_addr;
  logic [7:0]  s_mem_wdata;
  logic [15:0] s_word_count;

  instr_mem_loader #(.MEM_BYTES(65536)) u_dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  instr_mem_loader #(.MEM_BYTES(16)) u_small (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_word(in_word), .in_last(in_last),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .busy(s_busy), .done(s_done), .error(s_error), .word_count(s_word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  typedef struct {
    bit          sel;
    logic [63:0] base;
    int          n;
    bit          use_last;
    int          vmode;
    bit          noise;
    logic [31:0] w0, w1, w2;
    bit          exp_err;
    int          exp_wc;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_m = 0, done_s = 0, viol = 0;
  wr_t         log_m[$], log_s[$];
  int          hs_q[$];
  logic [31:0] words[8];
  logic [63:0] ea[$];
  logic [7:0]  ed[$];
  int          m_hs;
  vec_t        tbl[10];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) log_m.push_back('{mem_addr, mem_wdata, cyc});
    if (s_mem_we) log_s.push_back('{s_mem_addr, s_mem_wdata, cyc});
    if (done) done_m++;
    if (s_done) done_s++;
    if ((in_ready && (mem_we || error || done || !busy)) ||
        (s_in_ready && (s_mem_we || s_error || s_done || !s_busy))) viol++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit sel, logic [63:0] base, int n, bit ul, int vm, bit nz,
                              logic [31:0] w0, logic [31:0] w1, logic [31:0] w2, bit ee, int ewc);
    vec_t v;
    v.sel = sel; v.base = base; v.n = n; v.use_last = ul; v.vmode = vm; v.noise = nz;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.exp_err = ee; v.exp_wc = ewc;
    return v;
  endfunction

  // Reference: walk the words, emitting 4 little-endian bytes each, with the store-bounds rules.
  task automatic model(input bit sel, input logic [63:0] base, input int n, input bit ul,
                       output bit err, output int wc);
    logic [63:0] a, lim;
    lim = sel ? 64'd12 : 64'd65532;
    ea.delete(); ed.delete();
    err = 0; wc = 0; m_hs = 0; a = base;
    if (base % 4 != 0 || base > lim) begin
      err = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      m_hs++;
      for (int k = 0; k < 4; k++) begin
        ea.push_back(a + 64'(k));
        ed.push_back(8'(words[i] >> (8 * k)));
      end
      wc++;
      if (ul && i == n - 1) return;
      a = a + 64'd4;
      if (a > lim) begin
        err = 1;
        return;
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    log_m.delete(); log_s.delete(); hs_q.delete();
    done_m = 0; done_s = 0;
  endtask

  task automatic run_session(input bit sel, input logic [63:0] base, input int n, input bit ul,
                             input int vm, input bit nz);
    int idx, t;
    bit fin;
    apply_reset();
    @(posedge clk); #1;
    base_addr = base; start = 1'b1; in_valid = 1'b1;
    in_word = words[0]; in_last = ul && (n == 1);
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; t = 0; fin = 0;
    while (!fin) begin
      if (idx >= n) in_valid = 1'b0;
      else if (vm == 0) in_valid = 1'b1;
      else if (vm == 1) in_valid = !in_valid;
      else in_valid = 1'($urandom_range(0, 1));
      if (nz) start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if ((sel ? s_in_ready : in_ready) && in_valid) begin
        hs_q.push_back(cyc);
        idx++;
      end
      if ((sel ? s_done : done) || (sel ? s_error : error)) fin = 1;
      t++;
      if (t > 400 && !fin) begin
        n_chk++; n_fail++;
        $display("FAIL session_timeout: got no done/error after %0d cycles, expected completion", t);
        fin = 1;
      end
      @(posedge clk); #1;
      if (idx < n) begin
        in_word = words[idx];
        in_last = ul && (idx == n - 1);
      end
    end
    start = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_session(input string tag, input bit sel, input int vm,
                               input bit exp_err, input int exp_wc);
    wr_t got[$];
    got = sel ? log_s : log_m;
    chk({tag, "_nwrites"}, 64'(got.size()), 64'(ea.size()));
    for (int j = 0; j < got.size() && j < ea.size(); j++) begin
      chk($sformatf("%s_w%0d_addr", tag, j), got[j].a, ea[j]);
      chk($sformatf("%s_w%0d_data", tag, j), 64'(got[j].d), 64'(ed[j]));
      if (j / 4 < hs_q.size())
        chk($sformatf("%s_w%0d_cycle", tag, j), 64'(got[j].c), 64'(hs_q[j / 4] + 1 + j % 4));
    end
    chk({tag, "_error"}, 64'(sel ? s_error : error), 64'(exp_err));
    chk({tag, "_word_count"}, 64'(sel ? s_word_count : word_count), 64'(exp_wc));
    chk({tag, "_done_pulses"}, 64'(sel ? done_s : done_m), exp_err ? 64'd0 : 64'd1);
    chk({tag, "_handshakes"}, 64'(hs_q.size()), 64'(m_hs));
    chk({tag, "_busy"}, 64'(sel ? s_busy : busy), 64'(exp_err));
    if (vm == 0)
      for (int i = 1; i < hs_q.size(); i++)
        chk($sformatf("%s_hs_gap%0d", tag, i), 64'(hs_q[i] - hs_q[i - 1]), 64'd5);
  endtask

  initial begin
    bit   m_err;
    int   m_wc;
    logic [63:0] b;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_word = '0; base_addr = '0;
    #3;
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_mem_we", 64'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", 64'(mem_wdata), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_error", 64'(error), 0);
    chk("rst_word_count", 64'(word_count), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    tbl[0] = mk(0, 64'h0,         1, 1, 0, 0, 32'h015A04B3, 0, 0, 0, 1);
    tbl[1] = mk(0, 64'h10,        3, 1, 0, 0, 32'h006382B3, 32'h404183B3, 32'h0053F133, 0, 3);
    tbl[2] = mk(0, 64'h6,         1, 1, 0, 0, 32'h11111111, 0, 0, 1, 0);
    tbl[3] = mk(0, 64'h10000,     1, 1, 0, 0, 32'h22222222, 0, 0, 1, 0);
    tbl[4] = mk(0, 64'hFFFC,      1, 1, 0, 0, 32'hDEADBEEF, 0, 0, 0, 1);
    tbl[5] = mk(0, 64'hFFF8,      3, 0, 0, 0, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 1, 2);
    tbl[6] = mk(0, 64'h20,        3, 1, 1, 1, 32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C, 0, 3);
    tbl[7] = mk(0, 64'h40,        2, 1, 2, 1, 32'hCAFEF00D, 32'h5A5AA5A5, 0, 0, 2);
    tbl[8] = mk(0, 64'h1_0000_0000, 1, 1, 0, 0, 32'h33333333, 0, 0, 1, 0);
    tbl[9] = mk(1, 64'h8,         3, 0, 0, 0, 32'h00000013, 32'h00100093, 32'h00200113, 1, 2);

    for (int i = 0; i < 10; i++) begin
      words[0] = tbl[i].w0; words[1] = tbl[i].w1; words[2] = tbl[i].w2;
      model(tbl[i].sel, tbl[i].base, tbl[i].n, tbl[i].use_last, m_err, m_wc);
      run_session(tbl[i].sel, tbl[i].base, tbl[i].n, tbl[i].use_last, tbl[i].vmode, tbl[i].noise);
      check_session($sformatf("tbl%0d", i), tbl[i].sel, tbl[i].vmode, tbl[i].exp_err, tbl[i].exp_wc);
    end

    for (int r = 0; r < 12; r++) begin
      int n, vm;
      n  = $urandom_range(1, 4);
      vm = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) words[i] = $urandom;
      if ($urandom_range(0, 3) == 0) b = 64'(65536 - 4 * $urandom_range(1, 6));
      else b = 64'(4 * $urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) b = b | 64'($urandom_range(1, 3));
      model(0, b, n, 1, m_err, m_wc);
      run_session(0, b, n, 1, vm, 1'($urandom_range(0, 1)));
      check_session($sformatf("rnd%0d", r), 0, vm, m_err, m_wc);
    end

    // Misaligned base: error next cycle, and a later start is ignored.
    apply_reset();
    @(posedge clk); #1;
    base_addr = 64'h6; start = 1'b1; in_valid = 1'b1; in_word = 32'h12345678; in_last = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("err6_error", 64'(error), 1);
    chk("err6_in_ready", 64'(in_ready), 0);
    chk("err6_busy", 64'(busy), 1);
    @(posedge clk); #1;
    base_addr = 64'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("err6_sticky_error", 64'(error), 1);
    chk("err6_no_writes", 64'(log_m.size()), 0);
    chk("err6_in_ready_after", 64'(in_ready), 0);
    chk("err6_no_done", 64'(done_m), 0);
    in_valid = 1'b0;

    // Reset during the second byte of a word: only byte 0 lands.
    apply_reset();
    @(posedge clk); #1;
    base_addr = 64'h0; start = 1'b1; in_valid = 1'b1; in_word = 32'hC0DE1234; in_last = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("rw_we_before", 64'(mem_we), 1);
    chk("rw_addr_before", mem_addr, 64'h1);
    reset = 1'b1;
    #1;
    chk("rw_mem_we", 64'(mem_we), 0);
    chk("rw_mem_addr", mem_addr, 0);
    chk("rw_mem_wdata", 64'(mem_wdata), 0);
    chk("rw_busy", 64'(busy), 0);
    chk("rw_in_ready", 64'(in_ready), 0);
    chk("rw_error", 64'(error), 0);
    chk("rw_word_count", 64'(word_count), 0);
    @(negedge clk);
    chk("rw_nwrites", 64'(log_m.size()), 1);
    if (log_m.size() > 0) begin
      chk("rw_byte0_addr", log_m[0].a, 64'h0);
      chk("rw_byte0_data", 64'(log_m[0].d), 64'h34);
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    chk("in_ready_outside_accept", 64'(viol), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter: MEM_BYTES, 65536, size of the byte-addressed instruction store in bytes; legal byte addresses are 0..MEM_BYTES-1.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a load session; sampled only in IDLE.
REQ-005 base_addr  input  64  first byte address of the session; latched on an accepted start.
REQ-006 in_valid  input  1  in_word and in_last are valid.
REQ-007 in_ready  output  1  loader can accept a word this cycle.
REQ-008 in_word  input  32  instruction word, bit 0 = LSB of the instruction.
REQ-009 in_last  input  1  this word ends the session.
REQ-010 mem_we  output  1  byte write strobe to the instruction store.
REQ-011 mem_addr  output  64  byte address of the current write.
REQ-012 mem_wdata  output  8  byte data of the current write.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at session completion.
REQ-015 error  output  1  sticky fault flag.
REQ-016 word_count  output  16  words fully written in the current session.

Function
REQ-017 FSM states SHALL be IDLE, ACCEPT, WRITE, DONE and ERROR; all outputs SHALL be registered or decoded from registered state only.
REQ-018 IDLE: on start=1, if base_addr[1:0]!=0 or base_addr>MEM_BYTES-4 go ERROR; else latch addr<=base_addr, word_count<=0, go ACCEPT.
REQ-019 ACCEPT: in_ready=1; a handshake occurs when in_valid=1; the FSM latches in_word and in_last, sets byte index to 0 and goes WRITE.
REQ-020 in_ready SHALL be 0 in every state other than ACCEPT; in_valid outside ACCEPT SHALL be ignored.
REQ-021 WRITE: for 4 consecutive cycles, with byte index k=0..3: mem_we=1, mem_addr=addr+k, mem_wdata=word[8k+7:8k] (little-endian).
REQ-022 After k=3: word_count increments, addr<=addr+4. If the latched in_last=1, go DONE. Otherwise, if addr+4>MEM_BYTES-4, go ERROR. Otherwise go ACCEPT.
REQ-023 Timing: a handshake in cycle N SHALL produce byte writes in cycles N+1..N+4. The next in_ready SHALL be no earlier than cycle N+5, giving a maximum throughput of 1 word per 5 cycles.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE; word_count SHALL hold its value until the next accepted start.
REQ-025 ERROR: error=1, mem_we=0, in_ready=0; the FSM SHALL remain in ERROR until reset, and start SHALL be ignored.
REQ-026 start in any state other than IDLE SHALL be ignored; start and in_valid together in IDLE SHALL only start the session and SHALL NOT consume the word.
REQ-027 mem_we SHALL be 0 in IDLE, ACCEPT, DONE and ERROR; mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-028 word_count SHALL wrap from 16'hFFFF to 0 without fault.

Reset
REQ-029 On reset, the loader SHALL immediately (asynchronously) enter IDLE with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0 and word_count=0.
REQ-030 Reset asserted mid-WRITE SHALL abandon the partial word with no further strobes; bytes already written are not rolled back.

Verification
REQ-031 base_addr=0, start, then one word 32'h015A04B3 with in_last=1 -> B3@0, 04@1, 5A@2, 01@3 on consecutive cycles; done pulses the next cycle; word_count=1.
REQ-032 base_addr=0x10, three words (00638 2B3, 404183B3, 0053F133; last on the third), in_valid held high -> 12 writes at 0x10..0x1B in little-endian byte order; in_ready high once every 5 cycles; word_count=3.
REQ-033 base_addr=0x6 -> ERROR the cycle after start, error=1, no mem_we, in_ready stays 0; subsequent start ignored until reset.
REQ-034 MEM_BYTES=16, base_addr=0x8, two words with no in_last -> writes at 0x8..0xF, then ERROR with error=1; the third word is never accepted.
REQ-035 Reset asserted during WRITE k=1 of a word at 0x0 -> mem_we drops immediately, only byte 0 is written, all outputs are at reset values, and busy=0.
REQ-036 in_valid toggling 1/0 while in ACCEPT, and start pulsed during WRITE -> only handshake cycles are consumed, no duplicate words are written, and the start pulse has no effect.
